// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ISTALL = 2'd1,
        DSTALL = 2'd2,
        TRAP   = 2'd3
    } state_t;

    localparam logic [2:0] RESULT_SRC_LOAD = 3'b001;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Per-stage stall/flush controls plus trap redirect.
    typedef struct packed {
        logic stall_fetch;
        logic stall_dec;
        logic stall_exec;
        logic stall_mem;
        logic flush_dec;
        logic flush_exec;
        logic flush_mem;
        logic trap_redirect;
    } ctl_t;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Execute-stage operand forwarding select for one source register.
module forward_unit
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_addr_e,
    input  logic [REG_ADDR_W-1:0] rd_addr_m,
    input  logic                  reg_we_m,
    input  logic [REG_ADDR_W-1:0] rd_addr_w,
    input  logic                  reg_we_w,
    output logic [1:0]            forward
);

    logic hit_m;
    logic hit_w;

    // x0 is hardwired, so a write to it never produces a usable result.
    assign hit_m = reg_we_m && (rd_addr_m != '0) && (rd_addr_m == rs_addr_e);
    assign hit_w = reg_we_w && (rd_addr_w != '0) && (rd_addr_w == rs_addr_e);

    always_comb begin
        forward = FWD_RF;
        if (hit_m) begin
            forward = FWD_M;
        end else if (hit_w) begin
            forward = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/forwarding controller with cache-miss and trap
// sequencing FSM and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_d,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_d,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_e,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_e,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_e,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_m,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_w,
    input  logic                  i_reg_we_e,
    input  logic                  i_reg_we_m,
    input  logic                  i_reg_we_w,
    input  logic [2:0]            i_result_src_e,
    input  logic                  i_branch_taken_e,
    input  logic                  i_trap_m,
    input  logic                  i_icache_miss,
    input  logic                  i_fetch_done,
    input  logic                  i_dcache_miss,
    input  logic                  i_mem_done,
    output logic                  o_stall_fetch,
    output logic                  o_stall_dec,
    output logic                  o_stall_exec,
    output logic                  o_stall_mem,
    output logic                  o_flush_dec,
    output logic                  o_flush_exec,
    output logic                  o_flush_mem,
    output logic [1:0]            o_forward_rs1,
    output logic [1:0]            o_forward_rs2,
    output logic                  o_trap_redirect,
    output logic [CNT_W-1:0]      o_stall_cnt
);

    state_t            state;
    state_t            next_state;
    state_t            out_state;
    logic              pend_i;
    logic              pend_eff;
    logic              load_use;
    ctl_t              ctl;
    logic [CNT_W-1:0]  stall_cnt;

    forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .rs_addr_e (i_rs1_addr_e),
        .rd_addr_m (i_rd_addr_m),
        .reg_we_m  (i_reg_we_m),
        .rd_addr_w (i_rd_addr_w),
        .reg_we_w  (i_reg_we_w),
        .forward   (o_forward_rs1)
    );

    forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .rs_addr_e (i_rs2_addr_e),
        .rd_addr_m (i_rd_addr_m),
        .reg_we_m  (i_reg_we_m),
        .rd_addr_w (i_rd_addr_w),
        .reg_we_w  (i_reg_we_w),
        .forward   (o_forward_rs2)
    );

    assign load_use = (i_result_src_e == RESULT_SRC_LOAD) && i_reg_we_e &&
                      (i_rd_addr_e != '0) &&
                      ((i_rd_addr_e == i_rs1_addr_d) || (i_rd_addr_e == i_rs2_addr_d));

    // I-miss still outstanding after this cycle; a same-cycle fetch_done wins.
    assign pend_eff = (pend_i || i_icache_miss) && !i_fetch_done;

    // State, pending I-miss flag and stall counter.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state     <= RUN;
            pend_i    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state  <= next_state;
            pend_i <= pend_eff;
            if (ctl.stall_fetch && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    // Mealy next-state and control decode; out_state is the state whose
    // outputs this cycle shows (the target state on a transition). A trap is
    // fully serviced in the cycle it is seen, so the FSM leaves TRAP's exit
    // target directly and the redirect stays a single cycle.
    always_comb begin
        out_state  = state;
        next_state = state;
        ctl        = '0;

        unique case (state)
            RUN: begin
                if (i_dcache_miss) begin
                    out_state = DSTALL;
                end else if (i_trap_m) begin
                    out_state = TRAP;
                end else if (i_icache_miss) begin
                    out_state = ISTALL;
                end
            end
            ISTALL: begin
                if (i_dcache_miss) begin
                    out_state = DSTALL;
                end else if (i_trap_m) begin
                    out_state = TRAP;
                end else if (i_fetch_done) begin
                    out_state = RUN;
                end
            end
            DSTALL: out_state = DSTALL;
            TRAP:   out_state = TRAP;
            default: out_state = RUN;
        endcase

        next_state = out_state;
        if (out_state == TRAP) begin
            next_state = pend_eff ? ISTALL : RUN;
        end else if ((state == DSTALL) && i_mem_done) begin
            next_state = pend_eff ? ISTALL : RUN;
        end

        unique case (out_state)
            RUN: begin
                if (i_branch_taken_e) begin
                    ctl.flush_dec  = 1'b1;
                    ctl.flush_exec = 1'b1;
                end else if (load_use) begin
                    ctl.stall_fetch = 1'b1;
                    ctl.stall_dec   = 1'b1;
                    ctl.flush_exec  = 1'b1;
                end
            end
            ISTALL: begin
                ctl.stall_fetch = 1'b1;
                ctl.flush_dec   = 1'b1;
                ctl.flush_exec  = i_branch_taken_e;
            end
            DSTALL: begin
                ctl.stall_fetch = 1'b1;
                ctl.stall_dec   = 1'b1;
                ctl.stall_exec  = 1'b1;
                ctl.stall_mem   = 1'b1;
            end
            TRAP: begin
                ctl.flush_dec     = 1'b1;
                ctl.flush_exec    = 1'b1;
                ctl.flush_mem     = 1'b1;
                ctl.trap_redirect = 1'b1;
            end
            default: ctl = '0;
        endcase

        // A held stage cannot also take a bubble.
        ctl.flush_dec  = ctl.flush_dec  && !ctl.stall_dec;
        ctl.flush_exec = ctl.flush_exec && !ctl.stall_exec;
        ctl.flush_mem  = ctl.flush_mem  && !ctl.stall_mem;

        if (i_arst) begin
            ctl = '0;
        end
    end

    assign o_stall_fetch   = ctl.stall_fetch;
    assign o_stall_dec     = ctl.stall_dec;
    assign o_stall_exec    = ctl.stall_exec;
    assign o_stall_mem     = ctl.stall_mem;
    assign o_flush_dec     = ctl.flush_dec;
    assign o_flush_exec    = ctl.flush_exec;
    assign o_flush_mem     = ctl.flush_mem;
    assign o_trap_redirect = ctl.trap_redirect;
    assign o_stall_cnt     = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (counter narrowed to 4 bits).
module tb_hazard_ctrl;

    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic [RW-1:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0;
    logic [RW-1:0] rd_e = '0, rd_m = '0, rd_w = '0;
    logic          we_e = 1'b0, we_m = 1'b0, we_w = 1'b0;
    logic [2:0]    res_src = 3'b000;
    logic          br = 1'b0, trap = 1'b0;
    logic          imiss = 1'b0, fdone = 1'b0, dmiss = 1'b0, mdone = 1'b0;

    logic          s_f, s_d, s_e, s_m, f_d, f_e, f_m, redir;
    logic [1:0]    fwd1, fwd2;
    logic [CW-1:0] cnt;
    logic [7:0]    ctl;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .i_clk(clk), .i_arst(arst),
        .i_rs1_addr_d(rs1_d), .i_rs2_addr_d(rs2_d),
        .i_rs1_addr_e(rs1_e), .i_rs2_addr_e(rs2_e),
        .i_rd_addr_e(rd_e), .i_rd_addr_m(rd_m), .i_rd_addr_w(rd_w),
        .i_reg_we_e(we_e), .i_reg_we_m(we_m), .i_reg_we_w(we_w),
        .i_result_src_e(res_src), .i_branch_taken_e(br), .i_trap_m(trap),
        .i_icache_miss(imiss), .i_fetch_done(fdone),
        .i_dcache_miss(dmiss), .i_mem_done(mdone),
        .o_stall_fetch(s_f), .o_stall_dec(s_d), .o_stall_exec(s_e), .o_stall_mem(s_m),
        .o_flush_dec(f_d), .o_flush_exec(f_e), .o_flush_mem(f_m),
        .o_forward_rs1(fwd1), .o_forward_rs2(fwd2),
        .o_trap_redirect(redir), .o_stall_cnt(cnt)
    );

    // {stall_fetch, stall_dec, stall_exec, stall_mem, flush_dec, flush_exec, flush_mem, redirect}
    assign ctl = {s_f, s_d, s_e, s_m, f_d, f_e, f_m, redir};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check controls for the current inputs, clock once, then check the counter.
    task automatic step(input string tag, input logic [7:0] exp_ctl);
        #1;
        chk(tag, 32'(ctl), 32'(exp_ctl));
        if (exp_ctl[7] && exp_cnt != 15) exp_cnt++;
        @(posedge clk);
        #1;
        chk({tag, "_cnt"}, 32'(cnt), 32'(exp_cnt));
    endtask

    localparam logic [7:0] C_IDLE   = 8'b0000_0000;
    localparam logic [7:0] C_LDUSE  = 8'b1100_0100;
    localparam logic [7:0] C_BRANCH = 8'b0000_1100;
    localparam logic [7:0] C_DSTALL = 8'b1111_0000;
    localparam logic [7:0] C_ISTALL = 8'b1000_1000;
    localparam logic [7:0] C_IST_BR = 8'b1000_1100;
    localparam logic [7:0] C_TRAP   = 8'b0000_1111;

    initial begin
        @(posedge clk);
        #1;
        arst = 1'b0;
        step("reset_idle", C_IDLE);

        // Forwarding priority and x0 exclusion
        rd_m = 5; we_m = 1; rd_w = 5; we_w = 1; rs1_e = 5; rs2_e = 5;
        #1; chk("fwd1_m", 32'(fwd1), 32'(2'b10)); chk("fwd2_m", 32'(fwd2), 32'(2'b10));
        we_m = 0;
        #1; chk("fwd1_w", 32'(fwd1), 32'(2'b01));
        rd_m = 0; rd_w = 0; we_m = 1;
        #1; chk("fwd1_x0", 32'(fwd1), 32'(2'b00)); chk("fwd2_x0", 32'(fwd2), 32'(2'b00));
        rd_m = 9; rs2_e = 9; rd_w = 5;
        #1; chk("fwd1_w_mix", 32'(fwd1), 32'(2'b01)); chk("fwd2_m_mix", 32'(fwd2), 32'(2'b10));
        we_m = 0; we_w = 0; rd_m = 0; rd_w = 0;

        // Load-use, branch squash, x0 load
        res_src = 3'b001; we_e = 1; rd_e = 7; rs2_d = 7;
        step("load_use", C_LDUSE);
        br = 1;
        step("load_use_branch", C_BRANCH);
        br = 0; rd_e = 0; rs2_d = 0;
        step("load_x0", C_IDLE);
        res_src = 3'b000; rd_e = 7; rs1_d = 7;
        step("alu_no_stall", C_IDLE);
        we_e = 0; rd_e = 0; rs1_d = 0;

        // D-cache miss: 5 stall cycles including mem_done cycle
        dmiss = 1;
        step("dmiss_entry", C_DSTALL);
        dmiss = 0;
        step("dstall_1", C_DSTALL);
        trap = 1; br = 1;
        step("dstall_trap_ignored", C_DSTALL);
        trap = 0; br = 0;
        step("dstall_3", C_DSTALL);
        mdone = 1;
        step("dstall_done", C_DSTALL);
        mdone = 0;
        step("dstall_exit_run", C_IDLE);

        // Nested I-miss then D-miss returns to ISTALL
        imiss = 1;
        step("imiss_entry", C_ISTALL);
        imiss = 0; br = 1;
        step("istall_branch", C_IST_BR);
        br = 0; dmiss = 1;
        step("nested_dmiss", C_DSTALL);
        dmiss = 0;
        step("nested_dstall", C_DSTALL);
        mdone = 1;
        step("nested_mdone", C_DSTALL);
        mdone = 0;
        step("back_to_istall", C_ISTALL);
        fdone = 1;
        step("fetch_done", C_IDLE);
        fdone = 0;
        step("run_after_fetch", C_IDLE);

        // Trap with branch in RUN: single cycle
        trap = 1; br = 1;
        step("trap_run", C_TRAP);
        trap = 0; br = 0;
        step("trap_exit_run", C_IDLE);

        // Trap during I-miss returns to ISTALL
        imiss = 1;
        step("imiss2", C_ISTALL);
        imiss = 0; trap = 1;
        step("trap_istall", C_TRAP);
        trap = 0;
        step("trap_exit_istall", C_ISTALL);
        fdone = 1;
        step("fetch_done2", C_IDLE);
        fdone = 0;

        // fetch_done during DSTALL clears the pending I-miss
        imiss = 1;
        step("imiss3", C_ISTALL);
        imiss = 0; dmiss = 1;
        step("dmiss3", C_DSTALL);
        dmiss = 0; fdone = 1;
        step("fdone_in_dstall", C_DSTALL);
        fdone = 0; mdone = 1;
        step("mdone3", C_DSTALL);
        mdone = 0;
        step("exit_run3", C_IDLE);

        // Reset mid-DSTALL
        dmiss = 1;
        step("dmiss4", C_DSTALL);
        dmiss = 0; arst = 1; trap = 1;
        #1; chk("no_redirect_in_reset", 32'(redir), 32'(1'b0));
        @(posedge clk);
        #1;
        arst = 0; trap = 0; exp_cnt = 0;
        #1; chk("post_reset_ctl", 32'(ctl), 32'(C_IDLE)); chk("post_reset_cnt", 32'(cnt), 32'(0));
        mdone = 1;
        step("mdone_ignored", C_IDLE);
        mdone = 0;

        // Counter saturation at 4'hF
        dmiss = 1;
        step("sat_entry", C_DSTALL);
        dmiss = 0;
        for (int i = 0; i < 18; i++) step("sat_hold", C_DSTALL);
        chk("sat_value", 32'(cnt), 32'(4'hF));
        mdone = 1;
        step("sat_done", C_DSTALL);
        mdone = 0;
        step("sat_exit", C_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush/forwarding controller for the 5-stage pipeline. It drives the stall and flush inputs of the decode, execute and memory pipeline registers, and the execute-stage forwarding selects. A small FSM sequences I-cache and D-cache miss stalls and trap redirects. It also keeps a saturating stall-cycle performance counter.

Parameters:
REG_ADDR_W, 5, register address width
CNT_W, 32, stall counter width

Ports:
i_clk  in  1  clock
i_arst  in  1  reset; synchronous, active-high
i_rs1_addr_d, i_rs2_addr_d  in  REG_ADDR_W  decode-stage source regs
i_rs1_addr_e, i_rs2_addr_e  in  REG_ADDR_W  execute-stage source regs
i_rd_addr_e, i_rd_addr_m, i_rd_addr_w  in  REG_ADDR_W  destination regs for the E, M and W stages
i_reg_we_e, i_reg_we_m, i_reg_we_w  in  1  register write enables per stage
i_result_src_e  in  3  execute result source; 3'b001 = load
i_branch_taken_e  in  1  taken branch/jump resolved in execute
i_trap_m  in  1  ecall/exception in memory stage
i_icache_miss, i_fetch_done  in  1  I-cache miss; refill complete (1-cycle pulse)
i_dcache_miss, i_mem_done  in  1  D-cache miss; refill complete (1-cycle pulse)
o_stall_fetch, o_stall_dec, o_stall_exec, o_stall_mem  out  1  per-stage register hold
o_flush_dec, o_flush_exec, o_flush_mem  out  1  per-stage bubble insert
o_forward_rs1, o_forward_rs2  out  2  00 = register file, 01 = W result, 10 = M result
o_trap_redirect  out  1  1-cycle PC redirect to trap vector
o_stall_cnt  out  CNT_W  saturating count of cycles with o_stall_fetch=1

Behaviour:
- State encoding: RUN, ISTALL, DSTALL, TRAP. Reset (i_arst sampled high at posedge) sets state=RUN, pend_i=0, o_stall_cnt=0.
- Control outputs are combinational from state and inputs. Immediately after reset (RUN, no hazard inputs) all stall, flush and redirect outputs are 0.
- Forwarding is combinational and independent of state.
  - rs1: o_forward_rs1=10 if i_reg_we_m and i_rd_addr_m!=0 and i_rd_addr_m==i_rs1_addr_e.
  - Else o_forward_rs1=01 if the same conditions hold for W.
  - Else o_forward_rs1=00.
  - M takes priority over W. rs2 uses the identical rule.
- RUN, combinational hazards:
  - Load-use: i_result_src_e==001 and i_reg_we_e and i_rd_addr_e!=0 and rd_e matches rs1_d or rs2_d. Response: stall_fetch=1, stall_dec=1, flush_exec=1.
  - Branch: i_branch_taken_e. Response: flush_dec=1, flush_exec=1.
  - Branch suppresses load-use (decode instruction is squashed).
- RUN transitions, in priority order:
  1. i_dcache_miss -> DSTALL
  2. i_trap_m -> TRAP
  3. i_icache_miss -> ISTALL
  - A transition cycle already drives the target state's outputs (Mealy).
- DSTALL:
  - Outputs: all four stalls=1, no flushes, no redirect.
  - On i_mem_done: next state = ISTALL if pend_i, else RUN. The i_mem_done cycle still stalls.
- ISTALL:
  - Outputs: stall_fetch=1, flush_dec=1. Execute, memory and writeback proceed.
  - The branch flush still applies (flush_exec on i_branch_taken_e).
  - i_dcache_miss -> DSTALL, with pend_i retained.
  - i_trap_m -> TRAP.
  - i_fetch_done -> RUN.
- TRAP (exactly 1 cycle):
  - Outputs: flush_dec=1, flush_exec=1, flush_mem=1, o_trap_redirect=1; no stalls.
  - Next state = ISTALL if pend_i, else RUN.
- pend_i:
  - Set when i_icache_miss=1 and state!=ISTALL-entry path.
  - Cleared on i_fetch_done; clear wins if both occur in the same cycle.
  - i_fetch_done arriving during DSTALL or TRAP clears pend_i, so the exit goes to RUN.
- Stall/flush conflict on the same stage: stall wins. The flush of a stalled stage is masked.
- o_stall_cnt:
  - Increments each cycle o_stall_fetch=1.
  - Saturates at all-ones; no wrap.
  - Reset to 0 only by i_arst.
- Reset mid-operation: any state returns to RUN next edge, with pend_i and the counter cleared. No pulse is produced on o_trap_redirect.
- Register x0 never triggers forwarding or load-use.

Decomposition:
- Shared package: state enum (RUN/ISTALL/DSTALL/TRAP), RESULT_SRC_LOAD=3'b001, and forward-select constants FWD_RF/FWD_W/FWD_M.
- One sub-module, forward_unit: purely combinational, instantiated once for each of rs1 and rs2.
- The FSM, hazard detection and counter stay in hazard_ctrl.

Test Plan:
- Forwarding: rd_m=5 we_m=1 and rd_w=5 we_w=1, rs1_e=5 -> o_forward_rs1=10. Drop we_m -> 01. Set rd=0 -> 00.
- Load-use: result_src_e=001, rd_e=7, rs2_d=7 -> 1 cycle of stall_fetch=stall_dec=flush_exec=1. Same cycle with branch_taken=1 -> only flush_dec=flush_exec=1.
- D-cache miss: dcache_miss at cycle 10, mem_done at cycle 14 -> all stalls=1 for cycles 10..14, RUN at 15, o_stall_cnt=5.
- Nested miss: icache_miss, then dcache_miss 2 cycles later, then mem_done -> returns to ISTALL. fetch_done -> RUN.
- Trap: trap_m and branch_taken together in RUN -> single cycle with flush_dec/exec/mem=1 and o_trap_redirect=1, then RUN.
- Reset mid-DSTALL: arst for 1 cycle -> next cycle all stalls 0, o_stall_cnt=0. Later mem_done is ignored.
